alu_acc_ctrl: RTL and testbench
===============================

ALU_ACC_CTRL -- requirements
Module: alu_acc_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have the following ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_load  in  1  1 = load accumulator with cmd_b; 0 = execute ALU op
- cmd_op  in  3  ALU opcode for execute
- cmd_b  in  4  load value or ALU b operand
- clr_ovf  in  1  synchronous clear of sticky overflow
- alu_a  out  4  ALU a operand, always equal to acc
- alu_b  out  4  registered ALU b operand
- alu_op  out  3  registered ALU opcode
- alu_result  in  4  combinational result from the ALU
- alu_overflow  in  1  combinational overflow from the ALU
- acc  out  4  accumulator
- ovf_sticky  out  1  OR of all captured overflows since reset or clear
- done  out  1  one-cycle pulse; command completed
- err  out  1  one-cycle pulse; illegal opcode rejected
- op_count  out  8  count of executed ALU ops, saturating

Function
REQ-003 The block SHALL implement an FSM with exactly three states: IDLE, EXEC and DONE.
REQ-004 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-005 An accepted command with cmd_load=1 SHALL do all of the following on the accept edge:
- set acc to cmd_b
- leave alu_b, alu_op, ovf_sticky and op_count unchanged
- move the FSM to DONE
REQ-006 An accepted command with cmd_load=0 and cmd_op in {000, 001, 100, 101, 110, 111} SHALL load alu_b with cmd_b and alu_op with cmd_op on the accept edge and move the FSM to EXEC.
REQ-007 An accepted command with cmd_load=0 and cmd_op in {010, 011} SHALL be rejected: no register other than the FSM changes, err is 1 for the following cycle, and the FSM moves to DONE.
REQ-008 On the rising edge that ends EXEC, the block SHALL do all of the following:
- set acc to alu_result
- OR alu_overflow into ovf_sticky
- increment op_count, saturating at 255
- move the FSM to DONE
REQ-009 In DONE the block SHALL drive done=1 for exactly one cycle and then return to IDLE; execute latency is therefore accept edge N, capture edge N+1, done high in the cycle after N+1, and cmd_ready high again after edge N+2.
REQ-010 The block SHALL accept at most one command per three cycles for execute and per two cycles for load or reject.
REQ-011 alu_a SHALL equal acc at all times, and alu_b and alu_op SHALL hold their values stable throughout EXEC.
REQ-012 clr_ovf=1 SHALL clear ovf_sticky on the next rising edge in any state.
REQ-013 When clr_ovf=1 on the same edge that captures alu_overflow=1, ovf_sticky SHALL be 1 (set wins).
REQ-014 cmd_valid while cmd_ready=0 SHALL be ignored, and the same command SHALL NOT be accepted twice unless the requester still holds cmd_valid when cmd_ready returns.
REQ-015 Chained execution SHALL use the prior acc as alu_a with no extra cycle.
REQ-016 acc SHALL wrap modulo 16 exactly as alu_result gives it, with no additional width logic in this block.

Reset
REQ-017 While rst=1, the block SHALL immediately drive:
- FSM = IDLE
- acc = 0, alu_b = 0, alu_op = 000
- ovf_sticky = 0, op_count = 0
- done = 0, err = 0, cmd_ready = 0
REQ-018 After rst deasserts, cmd_ready SHALL be 1 from the first cycle.
REQ-019 Reset asserted mid-EXEC SHALL abort the operation without capturing alu_result and without producing done.

Verification
REQ-020 The bench SHALL drive alu_result and alu_overflow directly and SHALL cover at least these scenarios:
- Load: cmd_load=1, cmd_b=1010 -> acc=1010 after the edge, done pulse next cycle, op_count=0.
- Execute: acc=1010, cmd_op=000, cmd_b=0100, bench drives alu_result=1110 and alu_overflow=0 during EXEC -> alu_a=1010, alu_b=0100, alu_op=000 in EXEC; acc=1110; op_count=1; done 2 cycles after accept.
- Overflow: execute with alu_overflow=1 -> ovf_sticky=1; next op with overflow 0 -> ovf_sticky stays 1; clr_ovf coincident with overflow 1 -> stays 1; clr_ovf alone -> 0.
- Illegal opcode: cmd_op=010 -> err pulse, acc, alu_op and op_count unchanged, no EXEC cycle.
- Saturation and back-pressure: 256 executes -> op_count=255 and holds; cmd_valid held through EXEC/DONE -> exactly one accept per 3 cycles.
- Reset mid-op: rst asserted during EXEC with alu_result=0111 -> acc=0000, no done, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: IDLE/EXEC/DONE sequencer that loads or updates a 4-bit accumulator from an external ALU, with sticky overflow and a saturating op count
module alu_acc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_b,
  input  logic       clr_ovf,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_overflow,
  output logic [3:0] acc,
  output logic       ovf_sticky,
  output logic       done,
  output logic       err,
  output logic [7:0] op_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] r_state;
  logic [3:0] r_acc;
  logic [3:0] r_b;
  logic [2:0] r_op;
  logic       r_ovf;
  logic       r_err;
  logic [7:0] r_cnt;
  logic       w_accept;
  logic       w_illegal;
  logic       w_exec;
  assign cmd_ready  = (r_state == IDLE) && !rst;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_illegal  = cmd_op[2:1] == 2'b01;
  assign w_exec     = r_state == EXEC;
  assign alu_a      = r_acc;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign acc        = r_acc;
  assign ovf_sticky = r_ovf;
  assign done       = r_state == DONE;
  assign err        = r_err;
  assign op_count   = r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= 4'd0;
      r_b     <= 4'd0;
      r_op    <= 3'd0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_err <= w_accept && !cmd_load && w_illegal;
      // a capture with overflow beats a coincident clear
      r_ovf <= (w_exec && alu_overflow) || (r_ovf && !clr_ovf);
      case (r_state)
        IDLE: if (w_accept) begin
          if (cmd_load) begin
            r_acc   <= cmd_b;
            r_state <= DONE;
          end else if (w_illegal) begin
            r_state <= DONE;
          end else begin
            r_b     <= cmd_b;
            r_op    <= cmd_op;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_acc   <= alu_result;
          r_cnt   <= r_cnt + {7'd0, r_cnt != 8'hff};
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb_alu_acc_ctrl: directed table-driven bench for alu_acc_ctrl with hand-written corner sequences
module tb_alu_acc_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_b = 4'd0;
  logic       clr_ovf = 1'b0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result = 4'd0;
  logic       alu_overflow = 1'b0;
  logic [3:0] acc;
  logic       ovf_sticky;
  logic       done;
  logic       err;
  logic [7:0] op_count;
  int checks = 0;
  int errors = 0;
  logic [3:0] m_acc = 4'd0;
  typedef struct {
    logic       ld;
    logic [2:0] op;
    logic [3:0] b;
    logic [3:0] res;
    logic       ovf;
    logic       clr;
    logic [3:0] e_acc;
    logic [3:0] e_b;
    logic [2:0] e_op;
    logic       e_ovf;
    logic       e_err;
    logic [7:0] e_cnt;
  } vec_t;
  vec_t tbl[10];
  alu_acc_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_b(cmd_b), .clr_ovf(clr_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_overflow(alu_overflow), .acc(acc), .ovf_sticky(ovf_sticky),
    .done(done), .err(err), .op_count(op_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int n;
    logic ex;
    ex = !v.ld && v.op[2:1] != 2'b01;
    n = 0;
    while (!cmd_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_load = v.ld;
    cmd_op = v.op;
    cmd_b = v.b;
    alu_result = v.res;
    alu_overflow = v.ovf;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (ex) begin
      chk("exec_alu_a", alu_a, m_acc);
      chk("exec_alu_b", alu_b, v.b);
      chk("exec_alu_op", alu_op, v.op);
      chk("exec_done", done, 0);
      chk("exec_ready", cmd_ready, 0);
      clr_ovf = v.clr;
      @(negedge clk);
      clr_ovf = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("err", err, v.e_err);
    chk("done_ready", cmd_ready, 0);
    chk("acc", acc, v.e_acc);
    chk("ovf_sticky", ovf_sticky, v.e_ovf);
    chk("op_count", op_count, v.e_cnt);
    chk("alu_b_hold", alu_b, v.e_b);
    chk("alu_op_hold", alu_op, v.e_op);
    m_acc = v.e_acc;
    @(negedge clk);
    chk("done_end", done, 0);
    chk("err_end", err, 0);
  endtask
  initial begin
    //         ld  op      b        res      ovf  clr  e_acc    e_b      e_op    e_ovf e_err e_cnt
    tbl[0] = '{1'b1, 3'b000, 4'b1010, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b0000, 3'b000, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 3'b000, 4'b0100, 4'b1110, 1'b0, 1'b0, 4'b1110, 4'b0100, 3'b000, 1'b0, 1'b0, 8'd1};
    tbl[2] = '{1'b0, 3'b001, 4'b0011, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0011, 3'b001, 1'b1, 1'b0, 8'd2};
    tbl[3] = '{1'b0, 3'b100, 4'b0001, 4'b0101, 1'b0, 1'b0, 4'b0101, 4'b0001, 3'b100, 1'b1, 1'b0, 8'd3};
    tbl[4] = '{1'b0, 3'b101, 4'b1111, 4'b1000, 1'b1, 1'b1, 4'b1000, 4'b1111, 3'b101, 1'b1, 1'b0, 8'd4};
    tbl[5] = '{1'b0, 3'b010, 4'b0110, 4'b0011, 1'b0, 1'b0, 4'b1000, 4'b1111, 3'b101, 1'b1, 1'b1, 8'd4};
    tbl[6] = '{1'b0, 3'b011, 4'b0001, 4'b0011, 1'b0, 1'b0, 4'b1000, 4'b1111, 3'b101, 1'b1, 1'b1, 8'd4};
    tbl[7] = '{1'b1, 3'b110, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b1111, 3'b101, 1'b1, 1'b0, 8'd4};
    tbl[8] = '{1'b0, 3'b110, 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0010, 3'b110, 1'b1, 1'b0, 8'd5};
    tbl[9] = '{1'b0, 3'b111, 4'b0111, 4'b1111, 1'b0, 1'b0, 4'b1111, 4'b0111, 3'b111, 1'b1, 1'b0, 8'd6};
    @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 10; i++) run(tbl[i]);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("clr_alone", ovf_sticky, 0);
    chk("clr_idle_done", done, 0);
    cmd_valid = 1'b1;
    cmd_load = 1'b0;
    cmd_op = 3'b000;
    cmd_b = 4'b0001;
    alu_result = 4'b0011;
    alu_overflow = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk("bp_ready", cmd_ready, (k % 3) == 0);
      chk("bp_done", done, (k % 3) == 2);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("bp_count", op_count, 9);
    chk("bp_ready_end", cmd_ready, 1);
    m_acc = 4'b0011;
    for (int i = 0; i < 256; i++) begin
      vec_t v;
      int c;
      c = 10 + i;
      v = '{1'b0, 3'b000, i[3:0], ~i[3:0], 1'b0, 1'b0, ~i[3:0], i[3:0], 3'b000, 1'b0, 1'b0, (c > 255) ? 8'd255 : c[7:0]};
      run(v);
    end
    cmd_valid = 1'b1;
    cmd_load = 1'b0;
    cmd_op = 3'b001;
    cmd_b = 4'b0101;
    alu_result = 4'b0111;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_in_exec", done, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_cnt", op_count, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    chk("mid_hold_done", done, 0);
    chk("mid_hold_acc", acc, 0);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", cmd_ready, 1);
    @(negedge clk);
    chk("mid_after_done", done, 0);
    chk("mid_after_acc", acc, 0);
    chk("mid_after_ready", cmd_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
